// File: rtl/ecc_pkg.sv
// Shared definitions for the scalar-multiplication sequencer and its point-unit bus.
package ecc_pkg;

  localparam int unsigned W = 4;

  localparam logic OP_DBL = 1'b0;
  localparam logic OP_ADD = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_DBL   = 3'd2,
    S_DBL_W = 3'd3,
    S_ADD   = 3'd4,
    S_ADD_W = 3'd5,
    S_NEXT  = 3'd6,
    S_FIN   = 3'd7
  } state_e;

endpackage

// File: rtl/ecc_scalar_seq_if.sv
// Command/result bus between the scalar sequencer (master) and the external point unit (slave).
interface ecc_scalar_seq_if;
  import ecc_pkg::*;

  logic           pu_start;
  logic           pu_op;
  logic [2*W-1:0] pu_cfg;
  logic [2*W-1:0] pu_q;
  logic [2*W-1:0] pu_p;
  logic           pu_done;
  logic           pu_inf;
  logic [2*W-1:0] pu_r;

  modport master (
    output pu_start, pu_op, pu_cfg, pu_q, pu_p,
    input  pu_done, pu_inf, pu_r
  );

  modport slave (
    input  pu_start, pu_op, pu_cfg, pu_q, pu_p,
    output pu_done, pu_inf, pu_r
  );

endinterface

// File: rtl/ecc_scalar_seq.sv
// MSB-first double-and-add sequencer for k*P; all field arithmetic lives in the external point unit.
module ecc_scalar_seq
  import ecc_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  prime,
  input  logic [W-1:0]  Px,
  input  logic [W-1:0]  Py,
  input  logic [W-1:0]  k,
  output logic [W-1:0]  kPx,
  output logic [W-1:0]  kPy,
  output logic          kP_inf,
  output logic          done,
  output logic          busy,
  ecc_scalar_seq_if.master pu
);

  state_e       state_q, state_d;
  logic [W-1:0] a_q, a_d, prime_q, prime_d;
  logic [W-1:0] px_q, px_d, py_q, py_d, k_q, k_d;
  logic [W-1:0] qx_q, qx_d, qy_q, qy_d;
  logic         qinf_q, qinf_d;
  logic [1:0]   idx_q, idx_d;
  logic [W-1:0] kpx_q, kpx_d, kpy_q, kpy_d;
  logic         kpinf_q, kpinf_d;
  logic         done_q, done_d, busy_q, busy_d;
  logic         pu_start_q, pu_start_d, pu_op_q, pu_op_d;
  logic         fin_go;

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    prime_d    = prime_q;
    px_d       = px_q;
    py_d       = py_q;
    k_d        = k_q;
    qx_d       = qx_q;
    qy_d       = qy_q;
    qinf_d     = qinf_q;
    idx_d      = idx_q;
    kpx_d      = kpx_q;
    kpy_d      = kpy_q;
    kpinf_d    = kpinf_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    pu_start_d = 1'b0;
    pu_op_d    = pu_op_q;
    fin_go     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          a_d     = a;
          prime_d = prime;
          px_d    = Px;
          py_d    = Py;
          k_d     = k;
          qx_d    = '0;
          qy_d    = '0;
          qinf_d  = 1'b1;
          idx_d   = 2'd3;
          busy_d  = 1'b1;
          state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        if (!qinf_q && qy_q != '0) begin
          state_d = S_DBL;
        end else begin
          qinf_d = 1'b1;
          // A skipped double with a clear bit folds NEXT into this cycle so k = 0 finishes quickly.
          if (k_q[idx_q])          state_d = S_ADD;
          else if (idx_q == 2'd0)  fin_go  = 1'b1;
          else                     idx_d   = idx_q - 2'd1;
        end
      end
      S_DBL: begin
        pu_start_d = 1'b1;
        pu_op_d    = OP_DBL;
        state_d    = S_DBL_W;
      end
      S_DBL_W: begin
        if (pu.pu_done) begin
          qx_d    = pu.pu_r[2*W-1:W];
          qy_d    = pu.pu_r[W-1:0];
          qinf_d  = pu.pu_inf;
          state_d = k_q[idx_q] ? S_ADD : S_NEXT;
        end
      end
      S_ADD: begin
        if (qinf_q) begin
          qx_d    = px_q;
          qy_d    = py_q;
          qinf_d  = 1'b0;
          state_d = S_NEXT;
        end else if (qx_q == px_q && qy_q != py_q) begin
          qinf_d  = 1'b1;
          state_d = S_NEXT;
        end else begin
          pu_start_d = 1'b1;
          pu_op_d    = (qx_q == px_q) ? OP_DBL : OP_ADD;
          state_d    = S_ADD_W;
        end
      end
      S_ADD_W: begin
        if (pu.pu_done) begin
          qx_d    = pu.pu_r[2*W-1:W];
          qy_d    = pu.pu_r[W-1:0];
          qinf_d  = pu.pu_inf;
          state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        if (idx_q == 2'd0) begin
          fin_go = 1'b1;
        end else begin
          idx_d   = idx_q - 2'd1;
          state_d = S_SCAN;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // The result registers load on entry to FIN, so done and the result appear together in FIN.
    if (fin_go) begin
      state_d = S_FIN;
      done_d  = 1'b1;
      kpinf_d = qinf_d;
      kpx_d   = qinf_d ? '0 : qx_d;
      kpy_d   = qinf_d ? '0 : qy_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      a_q        <= '0;
      prime_q    <= '0;
      px_q       <= '0;
      py_q       <= '0;
      k_q        <= '0;
      qx_q       <= '0;
      qy_q       <= '0;
      qinf_q     <= 1'b0;
      idx_q      <= '0;
      kpx_q      <= '0;
      kpy_q      <= '0;
      kpinf_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      pu_start_q <= 1'b0;
      pu_op_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      prime_q    <= prime_d;
      px_q       <= px_d;
      py_q       <= py_d;
      k_q        <= k_d;
      qx_q       <= qx_d;
      qy_q       <= qy_d;
      qinf_q     <= qinf_d;
      idx_q      <= idx_d;
      kpx_q      <= kpx_d;
      kpy_q      <= kpy_d;
      kpinf_q    <= kpinf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      pu_start_q <= pu_start_d;
      pu_op_q    <= pu_op_d;
    end
  end

  assign kPx         = kpx_q;
  assign kPy         = kpy_q;
  assign kP_inf      = kpinf_q;
  assign done        = done_q;
  assign busy        = busy_q;
  assign pu.pu_start = pu_start_q;
  assign pu.pu_op    = pu_op_q;
  assign pu.pu_cfg   = {a_q, prime_q};
  assign pu.pu_q     = {qx_q, qy_q};
  assign pu.pu_p     = {px_q, py_q};

endmodule

// File: tb/tb_ecc_scalar_seq.sv
// Bench for ecc_scalar_seq on y^2 = x^3 + x + 6 mod 11 with a 3-cycle behavioural point unit.
module tb_ecc_scalar_seq;
  import ecc_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [3:0] a_i, prime_i, px_i, py_i, k_i;
  logic [3:0] kpx, kpy;
  logic       kpinf, done, busy;

  int checks = 0;
  int errors = 0;

  ecc_scalar_seq_if pu_bus ();

  ecc_scalar_seq dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .a(a_i), .prime(prime_i), .Px(px_i), .Py(py_i), .k(k_i),
    .kPx(kpx), .kPy(kpy), .kP_inf(kpinf), .done(done), .busy(busy),
    .pu(pu_bus)
  );

  always #5 clk = ~clk;

  typedef struct {int x; int y; bit inf;} pt_t;

  function automatic int md(input int v, input int p);
    int r;
    r = v % p;
    if (r < 0) r += p;
    return r;
  endfunction

  function automatic int inv(input int v, input int p);
    for (int i = 1; i < p; i++) if (md(v * i, p) == 1) return i;
    return 0;
  endfunction

  function automatic pt_t pt_add(input pt_t p1, input pt_t p2, input int ca, input int p);
    pt_t r;
    int  lam;
    r.x = 0; r.y = 0; r.inf = 1'b0;
    if (p1.inf) return p2;
    if (p2.inf) return p1;
    if (p1.x == p2.x) begin
      if (p1.y != p2.y || p1.y == 0) begin
        r.inf = 1'b1;
        return r;
      end
      lam = md((3 * p1.x * p1.x + ca) * inv(md(2 * p1.y, p), p), p);
    end else begin
      lam = md(md(p2.y - p1.y, p) * inv(md(p2.x - p1.x, p), p), p);
    end
    r.x = md(lam * lam - p1.x - p2.x, p);
    r.y = md(lam * (p1.x - r.x) - p1.y, p);
    return r;
  endfunction

  function automatic pt_t ref_mul(input int kk, input pt_t p0);
    pt_t r;
    r.x = 0; r.y = 0; r.inf = 1'b1;
    for (int i = 0; i < kk; i++) r = pt_add(r, p0, 1, 11);
    return r;
  endfunction

  // Point-unit model plus command log
  int        pu_cnt = 0;
  int        pu_done_cnt = 0;
  pt_t       pu_res;
  logic      cmd_op[$];
  logic [7:0] cmd_q[$];
  logic [7:0] cmd_p[$];
  int        done_cnt = 0;

  always @(negedge clk) begin
    pt_t qq, pp;
    pu_bus.pu_done = 1'b0;
    if (pu_cnt > 0) begin
      pu_cnt--;
      if (pu_cnt == 0) begin
        pu_bus.pu_done = 1'b1;
        pu_bus.pu_inf  = pu_res.inf;
        pu_bus.pu_r    = {pu_res.x[3:0], pu_res.y[3:0]};
        pu_done_cnt++;
      end
    end
    if (pu_bus.pu_start === 1'b1) begin
      qq.x = int'(pu_bus.pu_q[7:4]); qq.y = int'(pu_bus.pu_q[3:0]); qq.inf = 1'b0;
      pp.x = int'(pu_bus.pu_p[7:4]); pp.y = int'(pu_bus.pu_p[3:0]); pp.inf = 1'b0;
      pu_res = (pu_bus.pu_op == OP_ADD)
             ? pt_add(qq, pp, int'(pu_bus.pu_cfg[7:4]), int'(pu_bus.pu_cfg[3:0]))
             : pt_add(qq, qq, int'(pu_bus.pu_cfg[7:4]), int'(pu_bus.pu_cfg[3:0]));
      pu_cnt = 3;
      cmd_op.push_back(pu_bus.pu_op);
      cmd_q.push_back(pu_bus.pu_q);
      cmd_p.push_back(pu_bus.pu_p);
    end
  end

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_op(input logic [3:0] kk, input logic [3:0] px, input logic [3:0] py,
                        output int cyc, output bit timeout);
    @(negedge clk);
    a_i = 4'd1; prime_i = 4'd11; px_i = px; py_i = py; k_i = kk; start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    cyc     = 1;
    timeout = 1'b1;
    while (cyc < 400) begin
      if (done === 1'b1) begin
        timeout = 1'b0;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [3:0] k, px, py, ex, ey;
    bit         einf;
    int         ecmds;
  } vec_t;

  initial begin
    vec_t tbl[7];
    pt_t  pts[$];
    pt_t  pe, pr;
    int   cyc, base, dbase, pdbase, got;
    bit   to;

    rst = 1'b1; start = 1'b0;
    a_i = '0; prime_i = '0; px_i = '0; py_i = '0; k_i = '0;

    tbl[0] = '{4'd0,  4'd2, 4'd7, 4'd0,  4'd0, 1'b1, 0};
    tbl[1] = '{4'd1,  4'd2, 4'd7, 4'd2,  4'd7, 1'b0, 0};
    tbl[2] = '{4'd2,  4'd2, 4'd7, 4'd5,  4'd2, 1'b0, 1};
    tbl[3] = '{4'd3,  4'd2, 4'd7, 4'd8,  4'd3, 1'b0, 2};
    tbl[4] = '{4'd4,  4'd2, 4'd7, 4'd10, 4'd2, 1'b0, 2};
    tbl[5] = '{4'd13, 4'd2, 4'd7, 4'd0,  4'd0, 1'b1, 4};
    tbl[6] = '{4'd15, 4'd2, 4'd7, 4'd5,  4'd2, 1'b0, 6};

    repeat (3) @(negedge clk);
    chk("rst_kpx", int'(kpx), 0);
    chk("rst_kpy", int'(kpy), 0);
    chk("rst_kpinf", int'(kpinf), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pu_start", int'(pu_bus.pu_start), 0);
    chk("rst_pu_op", int'(pu_bus.pu_op), 0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      base = cmd_q.size();
      run_op(tbl[i].k, tbl[i].px, tbl[i].py, cyc, to);
      chk($sformatf("tbl%0d_timeout", i), int'(to), 0);
      chk($sformatf("tbl%0d_busy", i), int'(busy), 1);
      chk($sformatf("tbl%0d_inf", i), int'(kpinf), int'(tbl[i].einf));
      chk($sformatf("tbl%0d_x", i), int'(kpx), int'(tbl[i].ex));
      chk($sformatf("tbl%0d_y", i), int'(kpy), int'(tbl[i].ey));
      chk($sformatf("tbl%0d_cmds", i), cmd_q.size() - base, tbl[i].ecmds);
      if (tbl[i].k == 4'd0) chk("k0_latency_le6", int'(cyc <= 6), 1);
      if (tbl[i].k == 4'd2 && cmd_q.size() > base) begin
        chk("k2_op", int'(cmd_op[base]), int'(OP_DBL));
        chk("k2_pu_q", int'(cmd_q[base]), 8'h27);
      end
      if (tbl[i].k == 4'd3 && cmd_q.size() > base + 1) begin
        chk("k3_op0", int'(cmd_op[base]), int'(OP_DBL));
        chk("k3_op1", int'(cmd_op[base+1]), int'(OP_ADD));
        chk("k3_pu_q", int'(cmd_q[base+1]), 8'h52);
        chk("k3_pu_p", int'(cmd_p[base+1]), 8'h27);
      end
      if (tbl[i].k == 4'd15 && cmd_q.size() > base)
        chk("k15_last_is_dbl", int'(cmd_op[cmd_op.size()-1]), int'(OP_DBL));
    end

    repeat (5) @(negedge clk);
    chk("hold_x", int'(kpx), 5);
    chk("hold_y", int'(kpy), 2);
    chk("hold_busy", int'(busy), 0);
    chk("hold_done", int'(done), 0);

    // Second start while busy is ignored
    base = cmd_q.size(); dbase = done_cnt;
    @(negedge clk);
    a_i = 4'd1; prime_i = 4'd11; px_i = 4'd2; py_i = 4'd7; k_i = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    k_i = 4'd1; px_i = 4'd3; py_i = 4'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 400 && got == 0; c++) begin
      if (done === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk("dbl_start_done_seen", got, 1);
    chk("dbl_start_x", int'(kpx), 8);
    chk("dbl_start_y", int'(kpy), 3);
    chk("dbl_start_inf", int'(kpinf), 0);
    repeat (10) @(negedge clk);
    chk("dbl_start_done_count", done_cnt - dbase, 1);
    chk("dbl_start_cmds", cmd_q.size() - base, 2);

    // Reset in DBL_W, then a stale pu_done, then a fresh start
    @(negedge clk);
    px_i = 4'd2; py_i = 4'd7; k_i = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 100 && got == 0; c++) begin
      if (pu_bus.pu_start === 1'b1) got = 1;
      else @(negedge clk);
    end
    chk("rst_mid_dbl_seen", got, 1);
    pdbase = pu_done_cnt;
    #2 rst = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    chk("midrst_state", int'(dut.state_q), int'(S_IDLE));
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pu_start", int'(pu_bus.pu_start), 0);
    chk("midrst_pu_op", int'(pu_bus.pu_op), 0);
    chk("midrst_kpx", int'(kpx), 0);
    chk("midrst_kpy", int'(kpy), 0);
    chk("midrst_kpinf", int'(kpinf), 0);
    repeat (6) @(negedge clk);
    chk("stale_done_issued", pu_done_cnt - pdbase, 1);
    chk("stale_state", int'(dut.state_q), int'(S_IDLE));
    chk("stale_busy", int'(busy), 0);
    chk("stale_done", int'(done), 0);
    chk("stale_kpx", int'(kpx), 0);
    chk("stale_kpy", int'(kpy), 0);
    base = cmd_q.size();
    run_op(4'd2, 4'd2, 4'd7, cyc, to);
    chk("fresh_timeout", int'(to), 0);
    chk("fresh_x", int'(kpx), 5);
    chk("fresh_y", int'(kpy), 2);
    chk("fresh_inf", int'(kpinf), 0);
    chk("fresh_cmds", cmd_q.size() - base, 1);

    // Random scalars and base points against repeated-addition reference
    for (int x = 0; x < 11; x++)
      for (int y = 0; y < 11; y++)
        if (md(y * y, 11) == md(x * x * x + x + 6, 11)) begin
          pe.x = x; pe.y = y; pe.inf = 1'b0;
          pts.push_back(pe);
        end
    chk("curve_point_count", pts.size(), 12);
    for (int n = 0; n < 30; n++) begin
      int kk, pi;
      kk = int'($urandom_range(0, 15));
      pi = int'($urandom_range(0, pts.size() - 1));
      pr = ref_mul(kk, pts[pi]);
      base = cmd_q.size();
      run_op(kk[3:0], pts[pi].x[3:0], pts[pi].y[3:0], cyc, to);
      chk($sformatf("rnd%0d_timeout", n), int'(to), 0);
      chk($sformatf("rnd%0d_inf k=%0d", n, kk), int'(kpinf), int'(pr.inf));
      chk($sformatf("rnd%0d_x k=%0d", n, kk), int'(kpx), pr.inf ? 0 : pr.x);
      chk($sformatf("rnd%0d_y k=%0d", n, kk), int'(kpy), pr.inf ? 0 : pr.y);
      chk($sformatf("rnd%0d_cmds_le8", n), int'((cmd_q.size() - base) <= 8), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_scalar_seq.md
ECC_SCALAR_SEQ -- requirements
Module: ecc_scalar_seq

Interface
REQ-001 The block SHALL have one clock, i_clk; reset i_rst SHALL be asynchronous and active-high.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_rst  input  1  async active-high reset.
REQ-004 i_start  input  1  request; sampled only in IDLE.
REQ-005 a, prime, Px, Py, k  input  4 each  curve coefficient, field prime, base point, scalar; captured on accepted i_start.
REQ-006 kPx, kPy  output  4 each  result point, valid from done and held until the next accepted i_start.
REQ-007 kP_inf  output  1  result is the point at infinity.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 busy  output  1  high from the accepted start through the done cycle.
REQ-010 pu_start  output  1  one-cycle command to the point unit.
REQ-011 pu_op  output  1  0 = DOUBLE(Q), 1 = ADD(Q,P).
REQ-012 pu_cfg, pu_q, pu_p  output  8 each  {a,prime}, {Qx,Qy}, {Px,Py} from registers, stable from pu_start until pu_done.
REQ-013 pu_done, pu_inf  input  1 each  point-unit completion pulse; its result is infinity.
REQ-014 pu_r  input  8  point-unit result {x,y}, valid when pu_done = 1.

Function
REQ-015 States: IDLE, SCAN, DBL, DBL_W, ADD, ADD_W, NEXT, FIN.
- IDLE + i_start: capture inputs, bit index i = 3, Q = infinity, go to SCAN.
REQ-016 SCAN handles the double step in one cycle:
- Q = infinity: skip the double.
- Qy = 0: set Q = infinity without issuing a command.
- Otherwise: go to DBL.
REQ-017 After the double step, if k[i] = 0 go to NEXT; otherwise go to ADD, with these cases:
- Q = infinity: load Q = P in one cycle, no command issued.
- Qx = Px and Qy = Py: issue DOUBLE instead of ADD.
- Qx = Px and Qy ≠ Py: set Q = infinity, no command issued.
REQ-018 DBL and ADD SHALL assert pu_start for exactly one cycle, then wait in *_W.
- On pu_done: Q = pu_r and Q-infinity flag = pu_inf.
- pu_done outside *_W SHALL be ignored.
REQ-019 No cycle limit SHALL be applied while waiting for pu_done.
REQ-020 NEXT: if i = 0 go to FIN; otherwise decrement i and go to SCAN.
REQ-021 FIN SHALL register the result and pulse done, then return to IDLE.
- Q = infinity: kPx = kPy = 0, kP_inf = 1.
REQ-022 i_start while busy SHALL be ignored, as SHALL i_start in the FIN cycle.
REQ-023 k = 0 SHALL complete with kP_inf = 1 and issue no pu_start.
REQ-024 No modular arithmetic SHALL be performed in this block; only 4-bit equality compares.
REQ-025 At most 8 commands SHALL be issued per operation.

Reset
REQ-026 i_rst SHALL force IDLE at any time, including mid-operation, and SHALL clear:
- done, busy, pu_start, pu_op;
- kPx, kPy, kP_inf;
- the Q, P, cfg and k registers and the bit index.
REQ-027 A pu_done arriving after a reset SHALL be ignored.

Structure
REQ-028 Shared package ecc_pkg SHALL hold:
- field width constant W = 4;
- pu_op encoding OP_DBL = 0, OP_ADD = 1;
- the state enumeration.
REQ-029 The block SHALL be a single module with no sub-module; the point unit is external.

Verification
Curve: y² = x³ + x + 6 mod 11, a = 1, prime = 11, P = (2,7); the bench uses a behavioural point-unit model with 3-cycle latency.
REQ-030 k = 0 -> no pu_start; done and kP_inf = 1 within 6 cycles of start.
REQ-031 k = 1 -> no pu_start; kPx = 2, kPy = 7, kP_inf = 0.
REQ-032 k = 2 -> exactly one DBL, with pu_q = (2,7); result (5,2).
REQ-033 k = 3 -> DBL then ADD, with pu_q = (5,2) and pu_p = (2,7); result (8,3).
REQ-034 Second start pulsed during k = 3 is ignored.
- The result is still (8,3).
- A single done is produced.
REQ-035 i_rst asserted in DBL_W with k = 3; a stale pu_done arrives after reset; a fresh k = 2 start follows.
- All outputs are 0 and the state is IDLE.
- The stale pu_done has no effect.
- The fresh start yields (5,2).
